// File: rtl/op_uart_responder.sv
// Byte-stream responder: assembles 0xA5-framed operands, drives the operator, returns 0x5A + result.
// Latency: final rhs byte to tx_valid is SETTLE_CYCLES+1 cycles; tx holds stable under tx_ready backpressure.
module op_uart_responder #(
  parameter int OPERAND_WIDTH = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [OPERAND_WIDTH-1:0] op_lhs,
  output logic [OPERAND_WIDTH-1:0] op_rhs,
  input  logic [OPERAND_WIDTH-1:0] op_result,
  output logic                     busy,
  output logic [7:0]               drop_count
);

  localparam int NBYTES = (OPERAND_WIDTH + 7) / 8;
  localparam int IDXW   = $clog2(NBYTES + 1);
  localparam int CNTW   = $clog2(SETTLE_CYCLES + 1);
  localparam int W      = OPERAND_WIDTH;

  typedef enum logic [2:0] {IDLE, RX_LHS, RX_RHS, WAIT, TX} state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q;
  logic [CNTW-1:0]   cnt_q;
  logic [W-1:0]      lhs_sh, rhs_sh, res_q;
  logic [W-1:0]      lhs_next, rhs_next;
  logic [IDXW+2:0]   sh;
  logic [7:0]        tx_byte;
  logic              rx_fire, tx_fire, last_byte, tx_last;

  assign rx_fire   = rx_valid && rx_ready;
  assign tx_fire   = tx_valid && tx_ready;
  assign last_byte = (idx_q == IDXW'(NBYTES - 1));
  assign tx_last   = (idx_q == IDXW'(NBYTES));
  assign busy      = (state_q != IDLE);

  // Byte idx lands at bit 8*idx; anything shifted above the operand width falls off.
  assign sh       = {idx_q, 3'b000};
  assign lhs_next = (lhs_sh & ~(W'(8'hFF) << sh)) | (W'(rx_data) << sh);
  assign rhs_next = (rhs_sh & ~(W'(8'hFF) << sh)) | (W'(rx_data) << sh);
  assign tx_byte  = 8'(res_q >> sh);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    rx_ready = 1'b0;
    case (state_q)
      IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid && rx_data == 8'hA5) state_d = RX_LHS;
      end
      RX_LHS: begin
        rx_ready = 1'b1;
        if (rx_valid && last_byte) state_d = RX_RHS;
      end
      RX_RHS: begin
        rx_ready = 1'b1;
        if (rx_valid && last_byte) state_d = WAIT;
      end
      WAIT:    if (cnt_q == '0) state_d = TX;
      TX:      if (tx_fire && tx_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      cnt_q      <= '0;
      lhs_sh     <= '0;
      rhs_sh     <= '0;
      res_q      <= '0;
      op_lhs     <= '0;
      op_rhs     <= '0;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      drop_count <= 8'h00;
    end else begin
      case (state_q)
        IDLE: if (rx_fire) begin
          if (rx_data == 8'hA5)        idx_q      <= '0;
          else if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
        RX_LHS: if (rx_fire) begin
          lhs_sh <= lhs_next;
          idx_q  <= last_byte ? '0 : idx_q + 1'b1;
        end
        RX_RHS: if (rx_fire) begin
          rhs_sh <= rhs_next;
          if (last_byte) begin
            idx_q  <= '0;
            op_lhs <= lhs_sh;
            op_rhs <= rhs_next;
            cnt_q  <= CNTW'(SETTLE_CYCLES);
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            res_q    <= op_result;
            tx_data  <= 8'h5A;
            tx_valid <= 1'b1;
            idx_q    <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        TX: if (tx_fire) begin
          // idx counts result bytes already loaded; NBYTES means the last one just left.
          if (!tx_last) begin
            tx_data <= tx_byte;
            idx_q   <= idx_q + 1'b1;
          end else begin
            tx_valid <= 1'b0;
            idx_q    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/op_uart_responder.md
Name: op_uart_responder

Overview:
- Device-side responder for on-hardware operator tests. It consumes a byte stream from a UART receiver (host to device) and assembles operand frames.
- It drives the injected operand side of an N-bit operator under test, waits a fixed settle time, then captures the result and streams a response frame back as bytes to a UART transmitter.
- It sits between the UART byte engines and the device-under-test in the device-level unit and integration test tops.

Parameters:
- OPERAND_WIDTH, 8: bitwidth of lhs, rhs and result. Must be ≥1.
- SETTLE_CYCLES, 2: cycles between driving operands and sampling op_result. Must be ≥1.
- NBYTES, derived (OPERAND_WIDTH+7)/8: bytes per operand on the wire. Not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- rx_data  input  8  received byte.
- rx_valid  input  1  rx_data is valid this cycle.
- rx_ready  output  1  responder accepts rx_data this cycle.
- tx_data  output  8  byte to transmit.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  transmitter accepts tx_data this cycle.
- op_lhs  output  OPERAND_WIDTH  operand to the DUT.
- op_rhs  output  OPERAND_WIDTH  operand to the DUT.
- op_result  input  OPERAND_WIDTH  DUT result; combinational from op_lhs and op_rhs.
- busy  output  1  high in every state except IDLE.
- drop_count  output  8  count of discarded non-sync bytes; saturates at 0xFF.

Behaviour:
- Transfer rules:
  - A byte transfers on a rising edge where valid && ready.
  - tx_data and tx_valid are registered. They must hold stable while tx_valid && !tx_ready.
- Reset: rst asynchronously forces the following, including mid-frame:
  - state to IDLE.
  - op_lhs, op_rhs, tx_data and drop_count to 0.
  - tx_valid to 0 and busy to 0.
  - the byte index to 0.
- Request frame: 0xA5, then NBYTES lhs bytes least-significant first, then NBYTES rhs bytes least-significant first.
  - Bits above OPERAND_WIDTH in the top byte are ignored.
- Response frame: 0x5A, then NBYTES result bytes least-significant first. Bits above OPERAND_WIDTH in the top byte are 0.
- FSM states and transitions:
  - IDLE: rx_ready=1.
    - On transfer of byte 0xA5: idx←0, go to RX_LHS.
    - On transfer of any other byte: drop_count increments (saturating), stay in IDLE.
  - RX_LHS: rx_ready=1.
    - Each transfer writes byte idx of a shadow lhs register.
    - After byte NBYTES-1: idx←0, go to RX_RHS.
  - RX_RHS: same as RX_LHS, writing a shadow rhs register.
    - On the last byte: op_lhs and op_rhs load from the shadows in the same edge (the final rhs byte bypasses into op_rhs), settle counter←SETTLE_CYCLES, go to WAIT.
  - WAIT: rx_ready=0.
    - The counter decrements each cycle.
    - When it reaches 0: capture op_result into a result register, load tx_data←0x5A, tx_valid←1, go to TX.
  - TX: rx_ready=0.
    - On a tx transfer, if bytes remain: tx_data←next result byte and tx_valid stays 1.
    - After the last result byte transfers: tx_valid←0, go to IDLE.
- Operand hold: op_lhs and op_rhs change only on the final rhs byte. They hold their values through WAIT, TX and the following IDLE.
- Latency: from the transfer of the final rhs byte to tx_valid rising is SETTLE_CYCLES+1 cycles.
- Back-to-back: with tx_ready held at 1, the response occupies NBYTES+1 consecutive cycles. IDLE accepts a new 0xA5 on the cycle after the last tx transfer.
- Sync inside a frame: a 0xA5 received in RX_LHS or RX_RHS is data, not a resync. There is no timeout.
- rx_valid is ignored while rx_ready=0; those bytes are upstream's responsibility.
- Idle-time drops: non-0xA5 bytes are counted only in IDLE.
- Width edge cases: OPERAND_WIDTH=1 gives NBYTES=1. OPERAND_WIDTH=9 gives NBYTES=2, with lhs[8] taken from bit 0 of byte 1.

Test Plan:
- Basic: W=16, SETTLE=2, tx_ready=1. Bench models AND. Send A5 34 12 0F 0F → op_lhs=0x1234, op_rhs=0x0F0F; tx_valid rises 3 cycles after the last rx byte; bytes 5A 04 02 appear.
- Backpressure: same frame, tx_ready toggled 0/1 every cycle → tx_data holds while stalled; the byte sequence is still 5A 04 02 with no duplicates; busy drops after 02 transfers.
- Garbage and sync: send 00 FF 5A then A5 FF 00 F0 00 → drop_count=3; response 5A F0 00.
- Sync byte as data and partial width: W=9, send A5 A5 01 FF 01 → lhs=0x1A5, rhs=0x1FF; result 0x1A5 sent as 5A A5 01.
- Reset mid-frame: assert rst asynchronously after A5 34 → busy=0 and op_lhs=0 immediately, with no clock edge needed. A following full frame completes normally.
- Saturation: send 300 non-sync bytes → drop_count=0xFF, stable.
